subbytes_sched: RTL
===================

# subbytes_sched

Time-shared S-box scheduler for the AES-128 core. Four forward `sbox` lanes and four `inv_sbox` lanes serve two requesters:
- the round datapath, which needs a 128-bit SubBytes/InvSubBytes in 4 beats;
- the key expander, which needs a 32-bit SubWord in 1 beat.

The block arbitrates between the two, sequences the beats, holds the state result until it is consumed, and returns key results as a single-cycle pulse.

## Interface
- `KEY_PRIORITY`, default 1. 1 means the key expander always wins simultaneous requests. 0 means round-robin, where the last-granted requester loses a tie.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  state job request.
- `st_ready`  out  1  state job accepted when `st_valid` and `st_ready` are both high.
- `st_data`  in  128  state in; byte i = `st_data[127-8i -: 8]`, i = 0..15.
- `st_inv`  in  1  0 selects SubBytes; 1 selects InvSubBytes.
- `st_out_valid`  out  1  state result available; held until consumed.
- `st_out_ready`  in  1  consumer takes the result.
- `st_out_data`  out  128  substituted state, same byte order as `st_data`.
- `kw_valid`  in  1  SubWord request.
- `kw_ready`  out  1  SubWord accepted.
- `kw_data`  in  32  word in; byte j = `kw_data[31-8j -: 8]`.
- `kw_out_valid`  out  1  one-cycle result pulse; no backpressure.
- `kw_out_data`  out  32  forward-S-box word.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States are IDLE, ST_RUN (beat counter 0..3), ST_DONE and KW_RUN.
- Lane k (k = 0..3) drives S-box inputs `x` = byte[7:4] and `y` = byte[3:0]. The S-box output bit [0] is the result MSB.
- Each lane mux selects `inv_sbox` when the latched mode is 1, else `sbox`. Key jobs always use forward.
- IDLE grant:
  - Only one valid: grant that requester.
  - Both valid: the `KEY_PRIORITY` rule decides.
  - `st_ready` = IDLE & grant_st. `kw_ready` = IDLE & grant_kw. Both are combinational from the valids.
  - At most one ready is high in any cycle.
- State accept:
  - Latch `st_data` and `st_inv`, then go to ST_RUN with beat = 0.
  - Beat b substitutes bytes 4b..4b+3 into the result register. The other bytes of that register are untouched.
  - After beat 3, go to ST_DONE.
- ST_DONE:
  - `st_out_valid` = 1 and `st_out_data` is stable.
  - When `st_out_ready` is high, clear valid and go to IDLE.
  - No new job is accepted while in ST_DONE.
- Key accept:
  - Latch `kw_data` and go to KW_RUN.
  - In KW_RUN, substitute all 4 bytes and register `kw_out_data`. Set `kw_out_valid` for the next cycle only, then return to IDLE.
- Round-robin bookkeeping: the last-grant flag updates only on an accept handshake.
- Changes to `st_data`, `st_inv` or `kw_data` after accept have no effect on the job in flight.
- Requests are never preempted. A key request arriving during ST_RUN or ST_DONE waits and is granted in the next IDLE cycle.

## Timing
- Reset:
  - State goes to IDLE and all outputs go to 0, including `st_out_data` and `kw_out_data`.
  - The last-grant flag is set to "state", so the first tie in round-robin mode goes to the key.
  - Reset mid-job discards the job; no result is produced.
- State latency:
  - Accept in cycle 0; beats run in cycles 1–4.
  - `st_out_valid` is high from cycle 5.
  - If `st_out_ready` is high in cycle 5, IDLE is entered in cycle 6, so `st_ready` can be high in cycle 6.
  - Minimum state-job spacing is 6 cycles.
- Key latency:
  - Accept in cycle 0; KW_RUN in cycle 1.
  - `kw_out_valid` is a pulse in cycle 2; IDLE is entered in cycle 2.
  - Back-to-back SubWords are possible every 2 cycles.
- `busy` is high in every non-IDLE cycle.
- `st_out_valid` and `kw_out_valid` are never high in the same cycle unless a key pulse coincides with the hold phase of a previous state result. That coincidence cannot occur, because no key job is accepted in ST_DONE.

## Test plan
- **Forward SubBytes.** Reset, then send `st_data`=00112233445566778899aabbccddeeff with `st_inv`=0.
  - Expect `st_out_data`=638293c31bfc33f5c4eeacea4bc12816 with `st_out_valid` rising exactly 5 cycles after accept.
- **InvSubBytes.** Send 638293c31bfc33f5c4eeacea4bc12816 with `st_inv`=1.
  - Expect 00112233445566778899aabbccddeeff.
- **SubWord.** Send `kw_data`=09cf4f3c.
  - Expect `kw_out_data`=018a84eb with a single-cycle `kw_out_valid` 2 cycles after accept.
- **Arbitration.** Raise both valids in the same IDLE cycle.
  - With `KEY_PRIORITY`=1: key is granted first, state on the next IDLE cycle.
  - With `KEY_PRIORITY`=0: over 4 repeated ties, grants alternate key, state, key, state.
- **Backpressure.** Hold `st_out_ready`=0 for 10 cycles while `kw_valid`=1.
  - Data stays stable and `kw_ready` stays 0.
  - On release, `kw_ready` rises the next cycle.
- **Reset mid-job.** Assert `rst` in beat 2.
  - All outputs are 0 the next cycle and no `st_out_valid` appears.
  - A new job afterwards produces correct results.

Source files
------------

// File: rtl/subbytes_sched_if.sv
// rtl/subbytes_sched_if.sv - request/result bundle for the time-shared S-box scheduler
interface subbytes_sched_if;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_data;
    logic         st_inv;
    logic         st_out_valid;
    logic         st_out_ready;
    logic [127:0] st_out_data;
    logic         kw_valid;
    logic         kw_ready;
    logic [31:0]  kw_data;
    logic         kw_out_valid;
    logic [31:0]  kw_out_data;
    logic         busy;

    modport slave (
        input  st_valid, st_data, st_inv, st_out_ready, kw_valid, kw_data,
        output st_ready, st_out_valid, st_out_data, kw_ready, kw_out_valid, kw_out_data, busy
    );

    modport master (
        output st_valid, st_data, st_inv, st_out_ready, kw_valid, kw_data,
        input  st_ready, st_out_valid, st_out_data, kw_ready, kw_out_valid, kw_out_data, busy
    );
endinterface

// File: rtl/subbytes_sched.sv
// rtl/subbytes_sched.sv - four-lane S-box scheduler shared by the round datapath and key expander
module subbytes_sched #(
    parameter bit KEY_PRIORITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    subbytes_sched_if.slave  sb
);

    typedef enum logic [1:0] {IDLE, ST_RUN, ST_DONE, KW_RUN} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Lane primitives take the byte as row/column nibbles and return the result LSB-first.
    function automatic logic [7:0] sbox(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] b;
        b = gf_inv({x, y});
        return bitrev8(b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
                       {b[3:0], b[7:4]} ^ 8'h63);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] s;
        s = {x, y};
        return bitrev8(gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05));
    endfunction

    state_t     state;
    state_t     state_nxt;
    logic [1:0] beat;
    logic       inv_mode;
    logic       last_kw;
    logic [7:0] st_in   [16];
    logic [7:0] res     [16];
    logic [7:0] kw_in   [4];
    logic [31:0] kw_out_q;
    logic       kw_out_v;

    logic       kw_wins;
    logic       grant_kw;
    logic       grant_st;
    logic       st_acc;
    logic       kw_acc;
    logic [7:0] lane_in  [4];
    logic [7:0] lane_out [4];

    // Round-robin: the requester granted last loses a tie.
    always_comb begin
        kw_wins     = KEY_PRIORITY ? 1'b1 : !last_kw;
        grant_kw    = sb.kw_valid & (!sb.st_valid | kw_wins);
        grant_st    = sb.st_valid & !grant_kw;
        sb.st_ready = (state == IDLE) & grant_st;
        sb.kw_ready = (state == IDLE) & grant_kw;
        st_acc      = sb.st_valid & sb.st_ready;
        kw_acc      = sb.kw_valid & sb.kw_ready;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_in[k]  = (state == KW_RUN) ? kw_in[k] : st_in[{beat, 2'(k)}];
            lane_out[k] = ((state == ST_RUN) && inv_mode)
                        ? bitrev8(inv_sbox(lane_in[k][7:4], lane_in[k][3:0]))
                        : bitrev8(sbox(lane_in[k][7:4], lane_in[k][3:0]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (st_acc)      state_nxt = ST_RUN;
                else if (kw_acc) state_nxt = KW_RUN;
            end
            ST_RUN:  if (beat == 2'd3) state_nxt = ST_DONE;
            ST_DONE: if (sb.st_out_ready) state_nxt = IDLE;
            KW_RUN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        sb.st_out_valid = (state == ST_DONE);
        sb.busy         = (state != IDLE);
        sb.kw_out_valid = kw_out_v;
        sb.kw_out_data  = kw_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= 2'd0;
            inv_mode <= 1'b0;
            last_kw  <= 1'b0;
            kw_out_v <= 1'b0;
            kw_out_q <= 32'h0;
            for (int i = 0; i < 16; i++) begin
                st_in[i] <= 8'h00;
                res[i]   <= 8'h00;
            end
            for (int j = 0; j < 4; j++) kw_in[j] <= 8'h00;
        end else begin
            kw_out_v <= (state == KW_RUN);
            if (st_acc) begin
                for (int i = 0; i < 16; i++) st_in[i] <= sb.st_data[127-8*i -: 8];
                inv_mode <= sb.st_inv;
                beat     <= 2'd0;
                last_kw  <= 1'b0;
            end
            if (kw_acc) begin
                for (int j = 0; j < 4; j++) kw_in[j] <= sb.kw_data[31-8*j -: 8];
                last_kw <= 1'b1;
            end
            if (state == ST_RUN) begin
                beat <= beat + 2'd1;
                for (int k = 0; k < 4; k++) res[{beat, 2'(k)}] <= lane_out[k];
            end
            if (state == KW_RUN)
                kw_out_q <= {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_pack
        assign sb.st_out_data[127-8*i -: 8] = res[i];
    end

endmodule
